pwm_multi: RTL

Multi-channel PWM generator with button-style duty control. N_CH channels share one period counter. Each channel holds its own duty register, adjusted in fixed steps by synchronised, edge-detected inc/dec pulses routed by a channel select. Duty changes are double-buffered and load only at a period boundary, so outputs never glitch. Edge-aligned or center-aligned mode is selectable at run time. Drives LED/motor outputs on the board.

---
 rtl/pwm_multi.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter and per-channel
// double-buffered duty registers adjusted by inc/dec button edges.
//
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   inc, dec        : async level inputs, one STEP per rising edge
//   ch_sel          : channel targeted by inc/dec (out of range ignored)
//   center          : 0 edge-aligned, 1 center-aligned (taken at boundary)
//   pwm_out         : PWM outputs, bit i = channel i
//   duty_sel        : shadow duty of channel ch_sel (0 if out of range)
//   period_start    : one-cycle pulse with the first output cycle of a period
module pwm_multi #(
    parameter int CW         = 8,
    parameter int N_CH       = 4,
    parameter int STEP       = 16,
    parameter int RESET_DUTY = 128,
    parameter int SELW       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            dec,
    input  logic [SELW-1:0] ch_sel,
    input  logic            center,
    output logic [N_CH-1:0] pwm_out,
    output logic [CW-1:0]   duty_sel,
    output logic            period_start
);

    localparam logic [CW-1:0] MAX    = '1;
    localparam logic [CW-1:0] TOP    = CW'(MAX - 1'b1);
    localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
    localparam logic [CW-1:0] STEP_N = CW'(STEP);
    localparam logic [CW-1:0] RST_D  = CW'(RESET_DUTY);

    typedef enum logic {UP, DOWN} phase_t;

    logic inc_s1, inc_s2, inc_prev, inc_edge;
    logic dec_s1, dec_s2, dec_prev, dec_edge;

    logic [CW-1:0] cnt, cnt_nxt;
    phase_t        phase, phase_nxt;
    logic          mode;
    logic          boundary;

    logic [CW-1:0] shadow [N_CH];
    logic [CW-1:0] active [N_CH];
    logic [CW-1:0] up_val [N_CH];
    logic [CW-1:0] dn_val [N_CH];

    logic step_up, step_dn;

    // Synchronise, then register the detected edge so that the
    // shadow update lands three edges after the input is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_s1   <= 1'b0;
            inc_s2   <= 1'b0;
            inc_prev <= 1'b0;
            inc_edge <= 1'b0;
            dec_s1   <= 1'b0;
            dec_s2   <= 1'b0;
            dec_prev <= 1'b0;
            dec_edge <= 1'b0;
        end else begin
            inc_s1   <= inc;
            inc_s2   <= inc_s1;
            inc_prev <= inc_s2;
            inc_edge <= inc_s2 & ~inc_prev;
            dec_s1   <= dec;
            dec_s2   <= dec_s1;
            dec_prev <= dec_s2;
            dec_edge <= dec_s2 & ~dec_prev;
        end
    end

    // Simultaneous inc and dec cancel out.
    assign step_up = inc_edge & ~dec_edge;
    assign step_dn = dec_edge & ~inc_edge;

    assign boundary = mode ? (phase == DOWN && cnt == '0)
                           : (cnt == TOP);

    // Center mode holds each endpoint for two cycles: the up->down
    // turn keeps TOP, and the boundary restart keeps 0.
    always_comb begin
        cnt_nxt   = cnt;
        phase_nxt = phase;
        if (boundary) begin
            cnt_nxt   = '0;
            phase_nxt = UP;
        end else if (phase == UP) begin
            if (cnt == TOP) begin
                phase_nxt = DOWN;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= UP;
            mode  <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            phase <= phase_nxt;
            if (boundary) begin
                mode <= center;
            end
        end
    end

    // Saturating step values, computed one bit wider to avoid wrap.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            logic [CW:0] sum;
            sum = {1'b0, shadow[i]} + STEP_W;
            up_val[i] = (sum > {1'b0, MAX}) ? MAX : sum[CW-1:0];
            dn_val[i] = (shadow[i] < STEP_N) ? '0
                                             : shadow[i] - STEP_N;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= RST_D;
                active[i] <= RST_D;
            end
            pwm_out      <= '0;
            period_start <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (int'(ch_sel) == i) begin
                    if (step_up) begin
                        shadow[i] <= up_val[i];
                    end else if (step_dn) begin
                        shadow[i] <= dn_val[i];
                    end
                end
                if (boundary) begin
                    active[i] <= shadow[i];
                end
                pwm_out[i] <= (cnt < active[i]);
            end
            period_start <= (cnt == '0) && (phase == UP);
        end
    end

    always_comb begin
        duty_sel = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(ch_sel) == i) begin
                duty_sel = shadow[i];
            end
        end
    end

endmodule
